quad_encoder_tx: RTL and testbench

QUAD_ENCODER_TX -- requirements
Module: quad_encoder_tx

---
 rtl/pong_pkg.sv | 30 +++
 rtl/step_rate_timer.sv | 33 +++
 rtl/quad_encoder_tx.sv | 124 ++++++++++++
 tb/tb_quad_encoder_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared quadrature encoder definitions: phase encoding, direction constants
// and the one-edge phase step used by the transmitter.
package pong_pkg;

  // Phase encodings are the literal {A,B} levels so the register bits can
  // drive the pins directly.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up walks 00 -> 10 -> 11 -> 01 -> 00; down walks the same ring backwards.
  function automatic phase_e phase_step(input phase_e ph, input logic dir);
    phase_e nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   if (dir == DIR_UP) nxt = PH_10; else nxt = PH_01;
      PH_10:   if (dir == DIR_UP) nxt = PH_11; else nxt = PH_00;
      PH_11:   if (dir == DIR_UP) nxt = PH_01; else nxt = PH_10;
      default: if (dir == DIR_UP) nxt = PH_00; else nxt = PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/step_rate_timer.sv
// Step-rate tick counter: counts enabled cycles and fires once the count
// reaches max(period,1)-1. The period is re-evaluated every cycle, so a
// shortened period fires immediately if the count is already past it.
module step_rate_timer #(
  parameter int TICKS_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic [TICKS_W-1:0] period,
  output logic               fire
);

  logic [TICKS_W-1:0] count;
  logic [TICKS_W-1:0] last;

  // Terminal count; a zero period behaves like one.
  always_comb begin
    last = '0;
    if (period != '0) last = period - TICKS_W'(1);
  end

  assign fire = run && (count >= last);

  // Count while running, restart on fire or on an external clear.
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (fire)      count <= '0;
    else if (run)       count <= count + TICKS_W'(1);
  end

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder transmitter: accepts +1/-1 step requests into a signed
// pending count and drains it as A/B quadrature edges at a programmable rate,
// tracking a signed 16-bit position.
// Optional: define QUAD_INDEX_EN to build the once-per-revolution index
// counter (CPR counts); without it index is tied low.
module quad_encoder_tx
  import pong_pkg::*;
#(
  parameter int TICKS_W = 16,
  parameter int PEND_W  = 8,
  parameter int CPR     = 96
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                step_valid,
  input  logic                step_dir,
  output logic                step_ready,
  input  logic [TICKS_W-1:0]  ticks_per_step,
  output logic                quadA,
  output logic                quadB,
  output logic                busy,
  output logic signed [15:0]  position,
  output logic                index
);

  localparam int                     PEND_MAX_I = (1 << (PEND_W - 1)) - 1;
  localparam logic signed [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_MAX_I);
  localparam logic signed [PEND_W-1:0] PEND_MIN = PEND_W'(-PEND_MAX_I);

  logic signed [PEND_W-1:0] pending;
  logic signed [PEND_W-1:0] pending_nxt;
  logic signed [PEND_W-1:0] acc_delta;
  logic signed [PEND_W-1:0] emit_delta;
  phase_e                   phase;
  logic                     accept;
  logic                     fire;
  logic                     run;
  logic                     clear;
  logic                     emit_up;

  // A request is refused only if it would push pending past the symmetric limit.
  function automatic logic req_fits(input logic signed [PEND_W-1:0] pend, input logic dir);
    if (dir == DIR_UP) return pend != PEND_MAX;
    else               return pend != PEND_MIN;
  endfunction

  assign step_ready = !reset && req_fits(pending, step_dir);
  assign accept     = step_valid && step_ready;
  assign busy       = (pending != '0);
  assign run        = enable && busy;
  assign emit_up    = !pending[PEND_W-1];
  assign clear      = (pending_nxt == '0);
  assign quadA      = phase[1];
  assign quadB      = phase[0];

  step_rate_timer #(
    .TICKS_W (TICKS_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .clear  (clear),
    .period (ticks_per_step),
    .fire   (fire)
  );

  // Net pending update: accepted request plus one count drained per edge.
  always_comb begin
    acc_delta  = '0;
    emit_delta = '0;
    if (accept) acc_delta  = (step_dir == DIR_UP) ? PEND_W'(1) : '1;
    if (fire)   emit_delta = emit_up ? PEND_W'(1) : '1;
    pending_nxt = pending + acc_delta - emit_delta;
  end

  // Pending, phase and position state; edges follow the sign of pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      phase    <= PH_00;
      position <= '0;
    end else begin
      pending <= pending_nxt;
      if (fire) begin
        phase    <= phase_step(phase, emit_up);
        position <= position + (emit_up ? 16'sd1 : -16'sd1);
      end
    end
  end

`ifdef QUAD_INDEX_EN
  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;

  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] idx_nxt;
  logic             index_q;

  // Index position within one revolution, wrapping in both directions.
  always_comb begin
    idx_nxt = idx_cnt;
    if (fire) begin
      if (emit_up) idx_nxt = (idx_cnt == IDX_W'(CPR - 1)) ? '0 : idx_cnt + IDX_W'(1);
      else         idx_nxt = (idx_cnt == '0) ? IDX_W'(CPR - 1) : idx_cnt - IDX_W'(1);
    end
  end

  // One-cycle marker after any edge that lands the revolution count on zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_cnt <= '0;
      index_q <= 1'b0;
    end else begin
      idx_cnt <= idx_nxt;
      index_q <= fire && (idx_nxt == '0);
    end
  end

  assign index = index_q;
`else
  assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Testbench for quad_encoder_tx: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_quad_encoder_tx;

  localparam int TICKS_W = 16;
  localparam int PEND_W  = 4;
  localparam int CPR     = 96;
  localparam int MAXP    = (1 << (PEND_W - 1)) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               step_valid;
  logic               step_dir;
  logic               step_ready;
  logic [TICKS_W-1:0] ticks_per_step;
  logic               quadA;
  logic               quadB;
  logic               busy;
  logic signed [15:0] position;
  logic               index;

  always #5 clk = ~clk;

  quad_encoder_tx #(
    .TICKS_W (TICKS_W),
    .PEND_W  (PEND_W),
    .CPR     (CPR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .step_valid     (step_valid),
    .step_dir       (step_dir),
    .step_ready     (step_ready),
    .ticks_per_step (ticks_per_step),
    .quadA          (quadA),
    .quadB          (quadB),
    .busy           (busy),
    .position       (position),
    .index          (index)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pos16(input int p);
    return 32'(p) & 32'h0000FFFF;
  endfunction

  task automatic drive(input logic r, input logic e, input logic v, input logic d, input int t);
    reset          = r;
    enable         = e;
    step_valid     = v;
    step_dir       = d;
    ticks_per_step = TICKS_W'(t);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, en, vld, dir;
    int   tps;
    logic ea, eb, ebusy;
    int   epos;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic v, input logic d, input int t,
                     input logic a, input logic b, input logic bz, input int p);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v; x.dir = d; x.tps = t;
    x.ea = a; x.eb = b; x.ebusy = bz; x.epos = p;
    tbl.push_back(x);
  endtask

  // ---------------- behavioural model ----------------
  int         m_pend, m_el, m_pos;
  logic       m_idx;
  logic [1:0] seq [4];

  function automatic logic m_ready(input logic d, input logic r);
    return !r && !(d ? (m_pend == MAXP) : (m_pend == -MAXP));
  endfunction

  function automatic logic [1:0] m_phase();
    return seq[((m_pos % 4) + 4) % 4];
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic v, input logic d, input int t);
    int   per, sg;
    logic acc, fire;
    if (r) begin
      m_pend = 0; m_el = 0; m_pos = 0; m_idx = 1'b0;
      return;
    end
    per  = (t < 1) ? 1 : t;
    acc  = v && m_ready(d, r);
    fire = e && (m_pend != 0) && (m_el >= per - 1);
    sg   = (m_pend > 0) ? 1 : -1;
    m_idx = 1'b0;
    if (fire) begin
      m_pos  += sg;
      m_pend -= sg;
      m_el    = 0;
`ifdef QUAD_INDEX_EN
      m_idx = ((((m_pos % CPR) + CPR) % CPR) == 0);
`endif
    end else if (e && (m_pend != 0)) begin
      m_el++;
    end
    if (acc) m_pend += d ? 1 : -1;
    if (m_pend == 0) m_el = 0;
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    drive(1, 0, 0, 0, 4);

    // reset state, single up step at 4 ticks
    add(1,0,0,0,4, 0,0,0,0);
    add(0,1,1,1,4, 0,0,1,0);
    add(0,1,0,0,4, 0,0,1,0);
    add(0,1,0,0,4, 0,0,1,0);
    add(0,1,0,0,4, 0,0,1,0);
    add(0,1,0,0,4, 1,0,0,1);
    add(0,1,0,0,4, 1,0,0,1);
    // five back-to-back down steps at 1 tick
    add(1,1,0,0,1, 0,0,0,0);
    add(0,1,1,0,1, 0,0,1,0);
    add(0,1,1,0,1, 0,1,1,-1);
    add(0,1,1,0,1, 1,1,1,-2);
    add(0,1,1,0,1, 1,0,1,-3);
    add(0,1,1,0,1, 0,0,1,-4);
    add(0,1,0,0,1, 0,1,0,-5);
    add(0,1,0,0,1, 0,1,0,-5);
    // ticks_per_step = 0 acts as 1
    add(1,1,0,0,0, 0,0,0,0);
    add(0,1,1,1,0, 0,0,1,0);
    add(0,1,0,0,0, 1,0,0,1);
    add(0,1,0,0,0, 1,0,0,1);
    // enable low holds emission, request still accepted
    add(1,0,0,0,1, 0,0,0,0);
    add(0,0,1,1,1, 0,0,1,0);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,1,0,0,1, 1,0,0,1);
    // reversal cancels to zero and clears the tick counter
    add(1,1,0,0,3, 0,0,0,0);
    add(0,1,1,1,3, 0,0,1,0);
    add(0,1,0,0,3, 0,0,1,0);
    add(0,1,1,0,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,1,1,3, 0,0,1,0);
    add(0,1,0,0,3, 0,0,1,0);
    add(0,1,0,0,3, 0,0,1,0);
    add(0,1,0,0,3, 1,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].dir, tbl[i].tps);
      step_clk();
      chk($sformatf("vec%0d.A", i), quadA, tbl[i].ea);
      chk($sformatf("vec%0d.B", i), quadB, tbl[i].eb);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].ebusy);
      chk($sformatf("vec%0d.pos", i), {16'h0, position}, pos16(tbl[i].epos));
      if (tbl[i].rst) chk($sformatf("vec%0d.index", i), index, 1'b0);
    end

    // pending saturation with enable low
    drive(1, 0, 0, 0, 1); step_clk();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 1, 1); #1;
      chk($sformatf("sat.ready%0d", i), step_ready, (i < 7));
      step_clk();
    end
    drive(0, 0, 1, 0, 1); #1;
    chk("sat.down_ready", step_ready, 1'b1);
    step_clk();
    chk("sat.busy_held", busy, 1'b1);
    chk("sat.pos_held", {16'h0, position}, pos16(0));
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step_clk();
    chk("sat.pos_drained", {16'h0, position}, pos16(6));
    chk("sat.busy_drained", busy, 1'b0);

    // down request coinciding with an edge at pending = +3
    drive(1, 0, 0, 0, 2); step_clk();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 1, 2); step_clk(); end
    drive(0, 1, 0, 0, 2); step_clk();
    chk("coin.pre_pos", {16'h0, position}, pos16(0));
    drive(0, 1, 1, 0, 2); step_clk();
    chk("coin.AB", {quadA, quadB}, 2'b10);
    chk("coin.pos", {16'h0, position}, pos16(1));
    chk("coin.busy", busy, 1'b1);
    drive(0, 1, 0, 0, 2); step_clk();
    chk("coin.B_steady", quadB, 1'b0);
    chk("coin.pos_steady", {16'h0, position}, pos16(1));
    step_clk();
    chk("coin.AB2", {quadA, quadB}, 2'b11);
    chk("coin.pos2", {16'h0, position}, pos16(2));
    chk("coin.busy2", busy, 1'b0);
    for (int i = 0; i < 3; i++) step_clk();
    chk("coin.pos_final", {16'h0, position}, pos16(2));

    // reset during tick 2 of 4 with pending = 5
    drive(1, 0, 0, 0, 4); step_clk();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 1, 4); step_clk(); end
    drive(0, 1, 0, 0, 4); step_clk();
    drive(1, 1, 1, 1, 4); #1;
    chk("rst.ready_low", step_ready, 1'b0);
    step_clk();
    chk("rst.AB", {quadA, quadB}, 2'b00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.pos", {16'h0, position}, pos16(0));
    chk("rst.index", index, 1'b0);
    drive(0, 1, 0, 0, 4);
    for (int i = 0; i < 10; i++) step_clk();
    chk("rst.AB_after", {quadA, quadB}, 2'b00);
    chk("rst.busy_after", busy, 1'b0);
    chk("rst.pos_after", {16'h0, position}, pos16(0));

`ifdef QUAD_INDEX_EN
    begin
      int pulses, ppos;
      pulses = 0; ppos = 0;
      drive(1, 1, 0, 0, 1); step_clk();
      for (int c = 0; c < 100; c++) begin
        drive(0, 1, (c < 96), 1, 1);
        step_clk();
        if (index) begin pulses++; ppos = int'(position); end
      end
      chk("idx.pulses96", 32'(pulses), 32'd1);
      chk("idx.pulse_pos", 32'(ppos), 32'd96);
      drive(0, 1, 1, 0, 1); step_clk();
      if (index) pulses++;
      drive(0, 1, 1, 1, 1); step_clk();
      if (index) pulses++;
      drive(0, 1, 0, 0, 1);
      for (int c = 0; c < 5; c++) begin
        step_clk();
        if (index) begin pulses++; ppos = int'(position); end
      end
      chk("idx.pulses_total", 32'(pulses), 32'd2);
      chk("idx.pulse_pos2", 32'(ppos), 32'd96);
    end
`endif

    // randomized run against the model
    begin
      int   tps, bias;
      logic r, e, v, d;
      tps = 1; bias = 50;
      drive(1, 1, 0, 0, tps);
      @(posedge clk); model_edge(1, 1, 0, 0, tps); #1;
      for (int c = 0; c < 3000; c++) begin
        if (c % 200 == 0) bias = $urandom_range(10, 90);
        if ($urandom_range(0, 15) == 0) tps = $urandom_range(0, 4);
        r = ($urandom_range(0, 99) == 0);
        e = ($urandom_range(0, 3) != 0);
        v = $urandom_range(0, 1);
        d = ($urandom_range(0, 99) < bias);
        drive(r, e, v, d, tps);
        @(negedge clk);
        chk("rnd.ready", step_ready, m_ready(d, r));
        chk("rnd.AB", {quadA, quadB}, m_phase());
        chk("rnd.busy", busy, (m_pend != 0));
        chk("rnd.pos", {16'h0, position}, pos16(m_pos));
        chk("rnd.index", index, m_idx);
        @(posedge clk);
        model_edge(r, e, v, d, tps);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
